// File: rtl/bus_arb_mux_pkg.sv
// Shared constants for the CPU bus arbiter: source indices, FSM encoding
// and arbitration mode selectors.
package cpu_bus_pkg;

    localparam int R0       = 0;
    localparam int R1       = 1;
    localparam int R2       = 2;
    localparam int R3       = 3;
    localparam int R4       = 4;
    localparam int R5       = 5;
    localparam int R6       = 6;
    localparam int R7       = 7;
    localparam int R8       = 8;
    localparam int R9       = 9;
    localparam int R10      = 10;
    localparam int R11      = 11;
    localparam int R12      = 12;
    localparam int R13      = 13;
    localparam int R14      = 14;
    localparam int R15      = 15;
    localparam int HI       = 16;
    localparam int LO       = 17;
    localparam int ZHIGH    = 18;
    localparam int ZLOW     = 19;
    localparam int PC       = 20;
    localparam int MDR      = 21;
    localparam int INPORT   = 22;
    localparam int CSIGNEXT = 23;

    localparam int ARB_PRIO = 0;
    localparam int ARB_RR   = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/bus_arb_mux_if.sv
// Source-side and consumer-side signals of the arbitrated bus.
// slave: the arbiter's view; master: the environment driving it.
interface bus_arb_mux_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 24
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_req;
    logic [NUM_SRC-1:0]        src_gnt;
    logic [DATA_W-1:0]         bus_out;
    logic                      bus_valid;
    logic                      bus_ready;
    logic [SEL_W-1:0]          bus_sel;
    logic                      bus_parity;
    logic                      conflict;
    logic [7:0]                conflict_cnt;
    logic                      clr_stats;

    modport slave (
        input  src_data, src_req, bus_ready, clr_stats,
        output src_gnt, bus_out, bus_valid, bus_sel, bus_parity, conflict, conflict_cnt
    );

    modport master (
        output src_data, src_req, bus_ready, clr_stats,
        input  src_gnt, bus_out, bus_valid, bus_sel, bus_parity, conflict, conflict_cnt
    );
endinterface

// File: rtl/bus_arb_mux_arb_pick.sv
// Find-first-set over req starting at ptr, wrapping from N-1 back to 0.
// With ptr=0 this degenerates to plain lowest-index priority.
module arb_pick
    import cpu_bus_pkg::*;
#(
    parameter int N     = 24,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic [N-1:0]     gnt,
    output logic             any
);

    logic [N-1:0] upper;

    // Prefer requesters at or above ptr; fall back to the lowest overall.
    always_comb begin
        upper = req & ({N{1'b1}} << ptr);
        idx   = '0;
        any   = |req;
        if (|upper) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (upper[i]) idx = SEL_W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) idx = SEL_W'(i);
            end
        end
        gnt = '0;
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/bus_arb_mux.sv
// N-source bus arbiter with a one-deep registered output stage.
// Optional macro BUS_ARB_PARITY_EN adds registered even parity on bus_parity;
// without it bus_parity is tied low.
//
// state | meaning
// EMPTY | no word held, bus_valid=0, bus_out keeps the last word
// FULL  | bus_out holds an untransferred word, bus_valid=1
module bus_arb_mux
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_SRC  = 24,
    parameter int ARB_MODE = ARB_PRIO
) (
    input  logic              clk,
    input  logic              rst,
    bus_arb_mux_if.slave      bus
);

    localparam int SEL_W = $clog2(NUM_SRC);

    bus_state_t        state_q, state_d;
    logic [SEL_W-1:0]  rr_ptr_q;
    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  win;
    logic [NUM_SRC-1:0] win_gnt;
    logic              any_req;
    logic              capture;
    logic              multi;
    logic [DATA_W-1:0] win_data;
    logic [DATA_W-1:0] bus_out_q;
    logic [SEL_W-1:0]  bus_sel_q;
    logic              conflict_q;
    logic [7:0]        conflict_cnt_q;

    // Fixed-priority mode always searches from index 0.
    assign pick_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    arb_pick #(
        .N     (NUM_SRC),
        .SEL_W (SEL_W)
    ) u_pick (
        .req (bus.src_req),
        .ptr (pick_ptr),
        .idx (win),
        .gnt (win_gnt),
        .any (any_req)
    );

    // More than one request bit set: clearing the lowest set bit leaves something.
    assign multi   = (bus.src_req & (bus.src_req - 1'b1)) != '0;
    assign capture = any_req && ((state_q == EMPTY) || bus.bus_ready);

    // Winner data mux.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win == SEL_W'(i)) win_data = bus.src_data[i*DATA_W +: DATA_W];
        end
    end

    // Next-state logic; a capture always lands in FULL, a drain with no new request empties.
    always_comb begin
        state_d = state_q;
        if (capture) begin
            state_d = FULL;
        end else if (state_q == FULL && bus.bus_ready) begin
            state_d = EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    // Output stage and round-robin pointer advance on capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_out_q <= '0;
            bus_sel_q <= '0;
            rr_ptr_q  <= '0;
        end else if (capture) begin
            bus_out_q <= win_data;
            bus_sel_q <= win;
            rr_ptr_q  <= (win == SEL_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
        end
    end

    // Conflict pulse and saturating counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            conflict_q <= capture && multi;
            if (bus.clr_stats) begin
                conflict_cnt_q <= '0;
            end else if (capture && multi && conflict_cnt_q != 8'hFF) begin
                conflict_cnt_q <= conflict_cnt_q + 8'd1;
            end
        end
    end

`ifdef BUS_ARB_PARITY_EN
    logic parity_q;

    // Parity of the captured word, kept in step with bus_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         parity_q <= 1'b0;
        else if (capture) parity_q <= ^win_data;
    end

    assign bus.bus_parity = parity_q;
`else
    assign bus.bus_parity = 1'b0;
`endif

    assign bus.src_gnt      = capture ? win_gnt : '0;
    assign bus.bus_out      = bus_out_q;
    assign bus.bus_sel      = bus_sel_q;
    assign bus.bus_valid    = (state_q == FULL);
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench for bus_arb_mux: one fixed-priority and one round-robin
// instance share clock and reset.
module tb_bus_arb_mux;
    import cpu_bus_pkg::*;

    localparam int DW = 32;
    localparam int NS = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bus_arb_mux_if #(.DATA_W(DW), .NUM_SRC(NS)) bp ();
    bus_arb_mux_if #(.DATA_W(DW), .NUM_SRC(NS)) br ();

    bus_arb_mux #(.DATA_W(DW), .NUM_SRC(NS), .ARB_MODE(ARB_PRIO)) u_prio (
        .clk (clk),
        .rst (rst),
        .bus (bp.slave)
    );

    bus_arb_mux #(.DATA_W(DW), .NUM_SRC(NS), .ARB_MODE(ARB_RR)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (br.slave)
    );

    task automatic test_reset();
        bp.src_data = '0; bp.src_req = '0; bp.bus_ready = 1'b0; bp.clr_stats = 1'b0;
        br.src_data = '0; br.src_req = '0; br.bus_ready = 1'b0; br.clr_stats = 1'b0;
        rst = 1'b0;
        #2;
        checks++;
        if (bp.bus_valid !== 1'b0 || bp.bus_out !== '0 || bp.bus_sel !== '0 ||
            bp.src_gnt !== '0 || bp.conflict !== 1'b0 || bp.conflict_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_state valid=%b out=%h sel=%0d gnt=%h conf=%b cnt=%0d expected all zero",
                     bp.bus_valid, bp.bus_out, bp.bus_sel, bp.src_gnt, bp.conflict, bp.conflict_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        bp.src_data[PC*DW +: DW] = 32'h0000_0010;
        bp.src_req   = 24'(1) << PC;
        bp.bus_ready = 1'b1;
        #1;
        checks++;
        if (bp.src_gnt !== (24'(1) << PC)) begin
            failures++;
            $display("FAIL single_gnt got=%h exp=%h", bp.src_gnt, 24'(1) << PC);
        end
        @(negedge clk);
        checks++;
        if (bp.bus_out !== 32'h10 || bp.bus_sel !== 5'd20 || bp.bus_valid !== 1'b1 || bp.conflict !== 1'b0) begin
            failures++;
            $display("FAIL single_capture out=%h sel=%0d valid=%b conf=%b exp out=10 sel=20 valid=1 conf=0",
                     bp.bus_out, bp.bus_sel, bp.bus_valid, bp.conflict);
        end
        bp.src_req = '0;
        @(negedge clk);
        checks++;
        if (bp.bus_valid !== 1'b0 || bp.bus_out !== 32'h10) begin
            failures++;
            $display("FAIL single_drain valid=%b out=%h exp valid=0 out=10", bp.bus_valid, bp.bus_out);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        bp.src_data[R2*DW +: DW] = 32'h22;
        bp.src_data[R4*DW +: DW] = 32'h24;
        bp.src_req   = (24'(1) << R2) | (24'(1) << R4);
        bp.bus_ready = 1'b1;
        #1;
        checks++;
        if (bp.src_gnt !== (24'(1) << R2)) begin
            failures++;
            $display("FAIL prio_gnt_first got=%h exp=%h", bp.src_gnt, 24'(1) << R2);
        end
        @(negedge clk);
        checks++;
        if (bp.bus_out !== 32'h22 || bp.conflict !== 1'b1 || bp.conflict_cnt !== 8'd1) begin
            failures++;
            $display("FAIL prio_first out=%h conf=%b cnt=%0d exp out=22 conf=1 cnt=1",
                     bp.bus_out, bp.conflict, bp.conflict_cnt);
        end
        bp.src_req = 24'(1) << R4;
        #1;
        checks++;
        if (bp.src_gnt !== (24'(1) << R4)) begin
            failures++;
            $display("FAIL prio_gnt_b2b got=%h exp=%h", bp.src_gnt, 24'(1) << R4);
        end
        @(negedge clk);
        checks++;
        if (bp.bus_out !== 32'h24 || bp.bus_sel !== 5'd4 || bp.bus_valid !== 1'b1 ||
            bp.conflict !== 1'b0 || bp.conflict_cnt !== 8'd1) begin
            failures++;
            $display("FAIL prio_b2b out=%h sel=%0d valid=%b conf=%b cnt=%0d exp out=24 sel=4 valid=1 conf=0 cnt=1",
                     bp.bus_out, bp.bus_sel, bp.bus_valid, bp.conflict, bp.conflict_cnt);
        end
        bp.src_req = '0;
        @(negedge clk);
        checks++;
        if (bp.bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL prio_drain valid=%b exp=0", bp.bus_valid);
        end
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 5, 23, 0};
        @(negedge clk);
        br.src_data[R0*DW +: DW]       = 32'hA0;
        br.src_data[R5*DW +: DW]       = 32'hA5;
        br.src_data[CSIGNEXT*DW +: DW] = 32'hB7;
        br.src_req   = (24'(1) << R0) | (24'(1) << R5) | (24'(1) << CSIGNEXT);
        br.bus_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (br.src_gnt !== (24'(1) << order[k])) begin
                failures++;
                $display("FAIL rr_gnt[%0d] got=%h exp=%h", k, br.src_gnt, 24'(1) << order[k]);
            end
            @(negedge clk);
            checks++;
            if (br.bus_sel !== 5'(order[k]) || br.bus_valid !== 1'b1) begin
                failures++;
                $display("FAIL rr_sel[%0d] got=%0d valid=%b exp=%0d valid=1", k, br.bus_sel, br.bus_valid, order[k]);
            end
        end
        checks++;
        if (br.bus_out !== 32'hA0 || br.conflict_cnt !== 8'd4) begin
            failures++;
            $display("FAIL rr_final out=%h cnt=%0d exp out=a0 cnt=4", br.bus_out, br.conflict_cnt);
        end
        br.src_req = '0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        @(negedge clk);
        bp.src_data[MDR*DW +: DW]    = 32'h4A92_0000;
        bp.src_data[INPORT*DW +: DW] = 32'h0000_0055;
        bp.src_req   = 24'(1) << MDR;
        bp.bus_ready = 1'b0;
        #1;
        checks++;
        if (bp.src_gnt !== (24'(1) << MDR)) begin
            failures++;
            $display("FAIL stall_first_gnt got=%h exp=%h", bp.src_gnt, 24'(1) << MDR);
        end
        @(negedge clk);
        bp.src_req = 24'(1) << INPORT;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bp.bus_out !== 32'h4A92_0000 || bp.bus_sel !== 5'd21 || bp.bus_valid !== 1'b1 || bp.src_gnt !== '0) begin
                failures++;
                $display("FAIL stall_hold[%0d] out=%h sel=%0d valid=%b gnt=%h exp out=4a920000 sel=21 valid=1 gnt=0",
                         k, bp.bus_out, bp.bus_sel, bp.bus_valid, bp.src_gnt);
            end
            @(negedge clk);
        end
        bp.bus_ready = 1'b1;
        #1;
        checks++;
        if (bp.src_gnt !== (24'(1) << INPORT)) begin
            failures++;
            $display("FAIL stall_release_gnt got=%h exp=%h", bp.src_gnt, 24'(1) << INPORT);
        end
        @(negedge clk);
        checks++;
        if (bp.bus_out !== 32'h55 || bp.bus_sel !== 5'd22 || bp.bus_valid !== 1'b1 || bp.conflict_cnt !== 8'd1) begin
            failures++;
            $display("FAIL stall_next out=%h sel=%0d valid=%b cnt=%0d exp out=55 sel=22 valid=1 cnt=1",
                     bp.bus_out, bp.bus_sel, bp.bus_valid, bp.conflict_cnt);
        end
        bp.src_req = '0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        bp.src_req   = (24'(1) << R0) | (24'(1) << R1);
        bp.bus_ready = 1'b1;
        repeat (254) @(negedge clk);
        checks++;
        if (bp.conflict_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_reach got=%0d exp=255", bp.conflict_cnt);
        end
        repeat (46) @(negedge clk);
        checks++;
        if (bp.conflict_cnt !== 8'd255 || bp.conflict !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold cnt=%0d conf=%b exp cnt=255 conf=1", bp.conflict_cnt, bp.conflict);
        end
        bp.clr_stats = 1'b1;
        @(negedge clk);
        checks++;
        if (bp.conflict_cnt !== 8'd0 || bp.conflict !== 1'b1) begin
            failures++;
            $display("FAIL sat_clear cnt=%0d conf=%b exp cnt=0 conf=1", bp.conflict_cnt, bp.conflict);
        end
        bp.clr_stats = 1'b0;
        bp.src_req   = '0;
        @(negedge clk);
        checks++;
        if (bp.conflict_cnt !== 8'd0 || bp.conflict !== 1'b0) begin
            failures++;
            $display("FAIL sat_after cnt=%0d conf=%b exp cnt=0 conf=0", bp.conflict_cnt, bp.conflict);
        end
    endtask

    task automatic test_async_reset();
        logic exp_par;
        @(negedge clk);
        bp.src_data[R3*DW +: DW] = 32'h1234_5678;
        bp.src_req   = (24'(1) << R3) | (24'(1) << R6);
        bp.bus_ready = 1'b0;
        @(negedge clk);
        bp.src_req = '0;
        checks++;
        if (bp.bus_valid !== 1'b1 || bp.conflict_cnt !== 8'd1) begin
            failures++;
            $display("FAIL areset_pre valid=%b cnt=%0d exp valid=1 cnt=1", bp.bus_valid, bp.conflict_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bp.bus_valid !== 1'b0 || bp.bus_out !== '0 || bp.conflict_cnt !== 8'd0 ||
            bp.bus_sel !== '0 || br.conflict_cnt !== 8'd0) begin
            failures++;
            $display("FAIL areset_now valid=%b out=%h cnt=%0d sel=%0d rr_cnt=%0d exp all zero",
                     bp.bus_valid, bp.bus_out, bp.conflict_cnt, bp.bus_sel, br.conflict_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bp.src_data[R7*DW +: DW] = 32'h0000_0007;
        bp.src_req   = 24'(1) << R7;
        bp.bus_ready = 1'b1;
        @(negedge clk);
        bp.src_req = '0;
`ifdef BUS_ARB_PARITY_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        checks++;
        if (bp.bus_out !== 32'h7 || bp.bus_parity !== exp_par) begin
            failures++;
            $display("FAIL parity out=%h par=%b exp out=7 par=%b", bp.bus_out, bp.bus_parity, exp_par);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_stall();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
Name: bus_arb_mux

Overview:
Parametrised successor to the datapath 32-to-1 bus multiplexer. N sources, each with its own data and request line, are arbitrated onto one registered DATA_W-bit bus. Arbitration is fixed-priority or round-robin. The winner's data is captured into a one-deep output stage with a valid/ready handshake. Multi-driver conflicts are flagged and counted. The block sits between the register file / special registers (HI, LO, Z, PC, MDR, InPort, C) and the ALU/memory consumers.

Parameters:
DATA_W, 32, bus width in bits
NUM_SRC, 24, number of bus sources (minimum 2)
ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin
SEL_W, derived localparam = $clog2(NUM_SRC), width of the encoded winner index

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
src_data  in  NUM_SRC*DATA_W  flattened source data; source i occupies bits [i*DATA_W +: DATA_W]
src_req  in  NUM_SRC  per-source drive request (replaces the per-register "out" strobes)
src_gnt  out  NUM_SRC  one-hot, one-cycle grant pulse issued in the capture cycle
bus_out  out  DATA_W  registered bus value
bus_valid  out  1  bus_out holds an untransferred word
bus_ready  in  1  consumer accepts bus_out this cycle
bus_sel  out  SEL_W  index of the source whose data is in bus_out
conflict  out  1  one-cycle pulse: more than one src_req bit was set at capture
conflict_cnt  out  8  saturating count of conflict events
clr_stats  in  1  synchronous clear of conflict_cnt

Behaviour:
- Reset (rst=0, asynchronous): bus_out=0, bus_valid=0, bus_sel=0, src_gnt=0, conflict=0, conflict_cnt=0, round-robin pointer=0, state=EMPTY.
- States: EMPTY (bus_valid=0) and FULL (bus_valid=1).
- capture = (|src_req) && (state==EMPTY || bus_ready).
- On capture, in the same cycle: src_gnt[w]=1 combinationally for the winner w. At the next edge: bus_out<=src_data[w], bus_sel<=w, state<=FULL.
- Latency: request to bus_valid is 1 cycle.
- FULL, bus_ready=1, no request: state<=EMPTY, bus_valid drops next cycle.
- FULL, bus_ready=1, request present: back-to-back capture. bus_valid stays 1 and the new word appears the next cycle (full throughput, no bubble).
- FULL, bus_ready=0: bus_out and bus_sel hold, src_gnt=0. Requesters keep src_req asserted until granted.
- EMPTY: bus_out keeps its last value (not cleared); bus_valid=0.
- ARB_MODE=0: lowest set index wins.
- ARB_MODE=1: search starts at pointer p and wraps NUM_SRC-1 -> 0. After each capture, p<=(w+1) mod NUM_SRC, with wrap when w=NUM_SRC-1. No capture leaves p unchanged.
- Conflict: when popcount(src_req)>1 in a capture cycle, conflict pulses high the next cycle and conflict_cnt increments, saturating at 255.
- Requests that arrive while stalled do not count as conflicts.
- clr_stats in the same cycle as a conflict increment: clear wins, cnt=0.
- bus_ready while EMPTY is ignored.
- src_req bits at index >= NUM_SRC do not exist; widths are exact.
- Reset mid-transfer: the word is dropped and the block enters EMPTY immediately, regardless of clk.

Optional Feature:
BUS_ARB_PARITY_EN
- Defined: bus_parity output (1 bit) is even parity (^) of the captured data, registered alongside bus_out. Reset value is 0.
- Not defined: bus_parity port still exists and is tied to 0. No parity logic is synthesised.

Decomposition:
- Package cpu_bus_pkg holds:
  - source index constants: R0..R15=0..15, HI=16, LO=17, ZHIGH=18, ZLOW=19, PC=20, MDR=21, INPORT=22, CSIGNEXT=23
  - state encoding (EMPTY=1'b0, FULL=1'b1)
  - ARB_MODE values (ARB_PRIO=0, ARB_RR=1)
- One sub-module, arb_pick: combinational find-first-set starting from a pointer with wraparound. It outputs the winner index, a one-hot grant and an any flag. The fixed-priority mode uses it with pointer=0.

Test Plan:
1. Reset, then src_req[20]=1 with PC data 32'h00000010, bus_ready=1 -> src_gnt[20] pulses in the same cycle; next cycle bus_out=32'h10, bus_sel=20, bus_valid=1; conflict=0.
2. ARB_MODE=0, src_req bits 2 and 4 set (R2=32'h22, R4=32'h24) -> R2 granted first, bus_out=32'h22, conflict=1 for one cycle, conflict_cnt=1. Then R4 is granted back-to-back and bus_out=32'h24 the next cycle.
3. ARB_MODE=1, src_req bits 0, 5 and 23 held for 4 captures, bus_ready=1 -> grant order 0, 5, 23, 0. The pointer wraps from 23 to 0.
4. Hold bus_ready=0 for 3 cycles while FULL with 32'h4A920000 -> bus_out, bus_sel and bus_valid are stable; src_gnt=0 throughout. On release, the transfer completes and the next request is captured.
5. Force 300 conflicting captures, then assert clr_stats together with a conflict -> count stops at 255, then reads 0 after the clear.
6. Assert rst low asynchronously between clock edges while FULL -> bus_valid=0, bus_out=0 and conflict_cnt=0 immediately. With BUS_ARB_PARITY_EN defined, the first capture of 32'h00000007 afterwards gives bus_parity=1.
